// File: rtl/cfeb_fiber_sync_fsm.sv
// Frame-marker alignment controller for one CFEB/DCFEB fiber: waits for a stable link,
// locks to the periodic FC marker, confirms its period, then monitors it while locked.
module cfeb_fiber_sync_fsm #(
    parameter int MARKER_PERIOD = 128,
    parameter int LINK_STABLE   = 8,
    parameter int NCONFIRM      = 3
) (
    input  logic       clock,
    input  logic       global_reset_n,
    input  logic       ttc_resync,
    input  logic       fiber_enable,
    input  logic       link_good,
    input  logic [7:0] kchar,
    input  logic       cnt_clear,
    output logic       sync_done,
    output logic       lost_sync,
    output logic [7:0] marker_err_cnt,
    output logic [2:0] sync_state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_LINK = 3'd1,
        HUNT      = 3'd2,
        CONFIRM   = 3'd3,
        DONE      = 3'd4,
        BYPASS    = 3'd5
    } state_t;

    localparam logic [8:0] PERIOD      = 9'(MARKER_PERIOD);
    localparam logic [7:0] STABLE_MAX  = 8'(LINK_STABLE);
    localparam logic [3:0] CONFIRM_MAX = 4'(NCONFIRM);
    localparam logic [7:0] K_FC        = 8'hFC;
    localparam logic [7:0] K_BC        = 8'hBC;

    state_t     state, state_n;
    logic [8:0] phase, phase_n, phase_inc;
    logic [3:0] confirm_cnt, confirm_n;
    logic [7:0] stable_cnt, stable_n;
    logic [7:0] err_cnt, err_cnt_n;
    logic       sync_done_n, lost_n;
    logic       err_seen, err_seen_n;
    logic       enable_q;
    logic       is_fc, is_bc, at_marker, marker_err, count_err;

    always_comb begin
        is_fc      = (kchar == K_FC);
        is_bc      = (kchar == K_BC);
        at_marker  = (phase == PERIOD);
        phase_inc  = at_marker ? 9'd1 : phase + 9'd1;
        // Same error definition serves CONFIRM (abandon lock) and DONE (count it).
        marker_err = (is_fc && !at_marker) || (!is_fc && at_marker) || (!is_fc && !is_bc);

        state_n    = state;
        phase_n    = phase;
        confirm_n  = confirm_cnt;
        stable_n   = 8'd0;
        lost_n     = lost_sync;
        err_seen_n = err_seen;
        count_err  = 1'b0;

        if (ttc_resync) begin
            state_n    = IDLE;
            lost_n     = 1'b0;
            phase_n    = 9'd0;
            confirm_n  = 4'd0;
            err_seen_n = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    phase_n    = 9'd0;
                    confirm_n  = 4'd0;
                    err_seen_n = 1'b0;
                    state_n    = fiber_enable ? WAIT_LINK : BYPASS;
                end
                BYPASS: begin
                    if (fiber_enable && !enable_q)
                        state_n = IDLE;
                end
                WAIT_LINK: begin
                    phase_n = 9'd0;
                    if (link_good) begin
                        stable_n = stable_cnt + 8'd1;
                        if (stable_n == STABLE_MAX)
                            state_n = HUNT;
                    end
                end
                HUNT: begin
                    if (!link_good) begin
                        state_n = WAIT_LINK;
                    end else if (is_fc) begin
                        phase_n   = 9'd1;
                        confirm_n = 4'd0;
                        state_n   = CONFIRM;
                    end
                end
                CONFIRM: begin
                    if (!link_good) begin
                        state_n   = WAIT_LINK;
                        confirm_n = 4'd0;
                    end else if (at_marker && is_fc) begin
                        confirm_n = confirm_cnt + 4'd1;
                        phase_n   = 9'd1;
                        if (confirm_n == CONFIRM_MAX) begin
                            state_n    = DONE;
                            err_seen_n = 1'b0;
                        end
                    end else if (marker_err) begin
                        state_n   = HUNT;
                        confirm_n = 4'd0;
                    end else begin
                        phase_n = phase_inc;
                    end
                end
                DONE: begin
                    phase_n = phase_inc;
                    if (!link_good) begin
                        state_n = WAIT_LINK;
                        lost_n  = 1'b1;
                    end else if (marker_err) begin
                        count_err = 1'b1;
                        // err_seen spans phases 1..PERIOD; a second error inside it drops lock.
                        if (err_seen) begin
                            state_n   = HUNT;
                            lost_n    = 1'b1;
                            confirm_n = 4'd0;
                        end else begin
                            err_seen_n = !at_marker;
                        end
                    end else if (at_marker) begin
                        err_seen_n = 1'b0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        sync_done_n = ((state == DONE) && (state_n == DONE)) ||
                      ((state == BYPASS) && (state_n == BYPASS));

        if (cnt_clear)
            err_cnt_n = count_err ? 8'd1 : 8'd0;
        else if (count_err && (err_cnt != 8'hFF))
            err_cnt_n = err_cnt + 8'd1;
        else
            err_cnt_n = err_cnt;
    end

    always_ff @(posedge clock or negedge global_reset_n) begin
        if (!global_reset_n) begin
            state       <= IDLE;
            phase       <= 9'd0;
            confirm_cnt <= 4'd0;
            stable_cnt  <= 8'd0;
            err_cnt     <= 8'd0;
            sync_done   <= 1'b0;
            lost_sync   <= 1'b0;
            err_seen    <= 1'b0;
            enable_q    <= 1'b0;
        end else begin
            state       <= state_n;
            phase       <= phase_n;
            confirm_cnt <= confirm_n;
            stable_cnt  <= stable_n;
            err_cnt     <= err_cnt_n;
            sync_done   <= sync_done_n;
            lost_sync   <= lost_n;
            err_seen    <= err_seen_n;
            enable_q    <= fiber_enable;
        end
    end

    assign marker_err_cnt = err_cnt;
    assign sync_state     = state;

endmodule

// File: tb/tb_cfeb_fiber_sync_fsm.sv
// Directed bench for cfeb_fiber_sync_fsm: lock-up, marker errors, loss of sync, relock,
// resync, error-counter saturation/clear and bypass.
module tb_cfeb_fiber_sync_fsm;

    localparam logic [7:0] K_FC = 8'hFC;
    localparam logic [7:0] K_BC = 8'hBC;
    localparam int         PER  = 128;

    logic       clock          = 1'b0;
    logic       global_reset_n = 1'b0;
    logic       ttc_resync     = 1'b0;
    logic       fiber_enable   = 1'b1;
    logic       link_good      = 1'b1;
    logic [7:0] kchar          = 8'hBC;
    logic       cnt_clear      = 1'b0;
    logic       sync_done;
    logic       lost_sync;
    logic [7:0] marker_err_cnt;
    logic [2:0] sync_state;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int next_fc  = 0;
    int m_cyc    = 0;
    int f_cyc    = 0;
    int l_cyc    = 0;

    cfeb_fiber_sync_fsm #(
        .MARKER_PERIOD(128),
        .LINK_STABLE  (8),
        .NCONFIRM     (3)
    ) dut (
        .clock         (clock),
        .global_reset_n(global_reset_n),
        .ttc_resync    (ttc_resync),
        .fiber_enable  (fiber_enable),
        .link_good     (link_good),
        .kchar         (kchar),
        .cnt_clear     (cnt_clear),
        .sync_done     (sync_done),
        .lost_sync     (lost_sync),
        .marker_err_cnt(marker_err_cnt),
        .sync_state    (sync_state)
    );

    always #5 clock = ~clock;

    // One clock edge; outputs are then sampled 1 time unit after it.
    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [7:0] k);
        kchar = k;
        tick();
    endtask

    // Runs the regular marker stream (FC at next_fc, BC otherwise) up to edge 'last'.
    task automatic run_until(input int last);
        while (cyc < last) begin
            if (cyc + 1 == next_fc) begin
                kchar = K_FC;
                next_fc += PER;
            end else begin
                kchar = K_BC;
            end
            tick();
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    initial begin
        // Reset values
        repeat (3) @(posedge clock);
        #1;
        check("rst_state", 8'(sync_state), 8'd0);
        check("rst_done", 8'(sync_done), 8'd0);
        check("rst_lost", 8'(lost_sync), 8'd0);
        check("rst_errcnt", marker_err_cnt, 8'd0);

        // Lock-up: first FC at cycle 20, sync_done at 20+385
        global_reset_n = 1'b1;
        cyc = 0;
        next_fc = 20;
        run_until(1);
        check("idle_one_clock", 8'(sync_state), 8'd1);
        run_until(8);
        check("wait_link_7", 8'(sync_state), 8'd1);
        run_until(9);
        check("hunt_after_8", 8'(sync_state), 8'd2);
        run_until(19);
        check("hunt_hold", 8'(sync_state), 8'd2);
        run_until(20);
        check("confirm_at_fc", 8'(sync_state), 8'd3);
        run_until(404);
        check("done_state_404", 8'(sync_state), 8'd4);
        check("done_low_404", 8'(sync_done), 8'd0);
        run_until(405);
        check("done_high_405", 8'(sync_done), 8'd1);
        check("errcnt_after_lock", marker_err_cnt, 8'd0);
        check("lost_after_lock", 8'(lost_sync), 8'd0);

        // One extra FC 5 clocks before the 660 marker: single error, lock kept
        run_until(654);
        send(K_FC);
        check("early_fc_cnt", marker_err_cnt, 8'd1);
        check("early_fc_done", 8'(sync_done), 8'd1);
        run_until(661);
        check("early_fc_cnt_hold", marker_err_cnt, 8'd1);
        check("early_fc_lost", 8'(lost_sync), 8'd0);
        check("early_fc_state", 8'(sync_state), 8'd4);

        // One bad k-char per period at phase 64, long enough to saturate
        for (int p = 0; p < 100; p++) begin
            run_until(next_fc - 65);
            send(8'h55);
            run_until(next_fc);
        end
        check("errcnt_101", marker_err_cnt, 8'd101);
        for (int p = 0; p < 158; p++) begin
            run_until(next_fc - 65);
            send(8'h55);
            run_until(next_fc);
        end
        check("errcnt_sat", marker_err_cnt, 8'd255);
        check("sat_still_done", 8'(sync_done), 8'd1);
        check("sat_state", 8'(sync_state), 8'd4);

        // cnt_clear on an error clock leaves 1; on a clean clock leaves 0
        run_until(next_fc - 65);
        cnt_clear = 1'b1;
        send(8'h55);
        cnt_clear = 1'b0;
        check("clear_on_err", marker_err_cnt, 8'd1);
        run_until(next_fc);
        cnt_clear = 1'b1;
        run_until(cyc + 1);
        cnt_clear = 1'b0;
        check("clear_clean", marker_err_cnt, 8'd0);

        // Marker moved 3 clocks early: error at phase 125 and missing FC at 128
        m_cyc = next_fc;
        run_until(m_cyc - 4);
        send(K_FC);
        check("drop_first_err", marker_err_cnt, 8'd1);
        check("drop_first_state", 8'(sync_state), 8'd4);
        next_fc = m_cyc + PER;
        send(K_BC);
        send(K_BC);
        check("drop_before", 8'(sync_done), 8'd1);
        send(K_BC);
        check("drop_state_hunt", 8'(sync_state), 8'd2);
        check("drop_done_low", 8'(sync_done), 8'd0);
        check("drop_lost", 8'(lost_sync), 8'd1);
        check("drop_errcnt", marker_err_cnt, 8'd2);
        run_until(m_cyc + 512);
        check("relock_state", 8'(sync_state), 8'd4);
        check("relock_done_low", 8'(sync_done), 8'd0);
        run_until(m_cyc + 513);
        check("relock_done", 8'(sync_done), 8'd1);
        check("relock_lost_sticky", 8'(lost_sync), 8'd1);

        // One-clock link drop while locked
        f_cyc = next_fc;
        l_cyc = f_cyc - 100;
        run_until(l_cyc - 1);
        link_good = 1'b0;
        run_until(l_cyc);
        link_good = 1'b1;
        check("link_drop_state", 8'(sync_state), 8'd1);
        check("link_drop_lost", 8'(lost_sync), 8'd1);
        check("link_drop_done", 8'(sync_done), 8'd0);
        run_until(l_cyc + 7);
        check("link_stable_7", 8'(sync_state), 8'd1);
        run_until(l_cyc + 8);
        check("link_stable_8", 8'(sync_state), 8'd2);
        run_until(f_cyc);
        check("link_relock_confirm", 8'(sync_state), 8'd3);
        run_until(f_cyc + 384);
        check("link_relock_state", 8'(sync_state), 8'd4);
        run_until(f_cyc + 385);
        check("link_relock_done", 8'(sync_done), 8'd1);
        check("link_errcnt", marker_err_cnt, 8'd2);

        // TTC resync
        ttc_resync = 1'b1;
        run_until(cyc + 1);
        ttc_resync = 1'b0;
        check("resync_state", 8'(sync_state), 8'd0);
        check("resync_lost", 8'(lost_sync), 8'd0);
        check("resync_done", 8'(sync_done), 8'd0);
        check("resync_errcnt", marker_err_cnt, 8'd2);
        run_until(cyc + 1);
        check("resync_wait_link", 8'(sync_state), 8'd1);

        // Bypass after reset with fiber disabled
        global_reset_n = 1'b0;
        fiber_enable = 1'b0;
        kchar = 8'h00;
        #1;
        check("byp_rst_state", 8'(sync_state), 8'd0);
        check("byp_rst_errcnt", marker_err_cnt, 8'd0);
        tick();
        global_reset_n = 1'b1;
        send(8'h00);
        check("byp_state_1", 8'(sync_state), 8'd5);
        check("byp_done_1", 8'(sync_done), 8'd0);
        send(8'h00);
        check("byp_state_2", 8'(sync_state), 8'd5);
        check("byp_done_2", 8'(sync_done), 8'd1);
        repeat (10) send(8'h00);
        check("byp_no_count", marker_err_cnt, 8'd0);
        check("byp_done_hold", 8'(sync_done), 8'd1);
        fiber_enable = 1'b1;
        send(8'h00);
        check("byp_exit_idle", 8'(sync_state), 8'd0);
        check("byp_exit_done", 8'(sync_done), 8'd0);
        send(8'h00);
        check("byp_exit_wait", 8'(sync_state), 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
